// File: rtl/rr_lease_arbiter.sv
// Four-way round-robin arbiter with registered one-hot grant, lease timer and one-cycle turnaround.
// Optional RR_ARB_LOCK_EN: owner-held lock freezes the lease counter and suppresses expiry.
module rr_lease_arbiter #(
    parameter int unsigned LEASE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       lock,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       expired
);

    localparam int unsigned CW = (LEASE_CYCLES > 0) ? $clog2(LEASE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      id_q, id_d;
    logic            valid_q, valid_d;
    logic            exp_q, exp_d;

    logic            freeze;
    logic            lease_hit;
    logic            pick_found;
    logic [1:0]      pick;
    logic [1:0]      scan;

`ifdef RR_ARB_LOCK_EN
    assign freeze = lock;
`else
    logic lock_unused;
    assign lock_unused = lock;
    assign freeze      = 1'b0;
`endif

    assign lease_hit = (LEASE_CYCLES != 0) && (cnt_q == CW'(LEASE_CYCLES));

    // First requester at or after the rotating pointer.
    always_comb begin
        pick_found = 1'b0;
        pick       = 2'd0;
        scan       = 2'd0;
        for (int unsigned k = 0; k < 4; k++) begin
            scan = ptr_q + 2'(k);
            if (!pick_found && req[scan]) begin
                pick_found = 1'b1;
                pick       = scan;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        exp_d   = 1'b0;
        case (state_q)
            ST_GRANT: begin
                if (!req[id_q]) begin
                    state_d = ST_GAP;
                    ptr_d   = id_q + 2'd1;
                    gnt_d   = 4'd0;
                    id_d    = 2'd0;
                    cnt_d   = '0;
                end else if (lease_hit && !freeze) begin
                    state_d = ST_GAP;
                    ptr_d   = id_q + 2'd1;
                    gnt_d   = 4'd0;
                    id_d    = 2'd0;
                    cnt_d   = '0;
                    exp_d   = 1'b1;
                end else if (!freeze && (cnt_q != {CW{1'b1}})) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE and GAP both arbitrate; GAP exists to force the turnaround cycle.
                state_d = ST_IDLE;
                gnt_d   = 4'd0;
                id_d    = 2'd0;
                cnt_d   = '0;
                if (pick_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = 4'(4'd1 << pick);
                    id_d    = pick;
                    cnt_d   = CW'(1);
                end
            end
        endcase
    end

    assign valid_d = |gnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'd0;
            id_q    <= 2'd0;
            valid_q <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            exp_q   <= exp_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;
    assign expired   = exp_q;

endmodule

// File: tb/tb_rr_lease_arbiter.sv
// Scoreboard bench for rr_lease_arbiter: a behavioural model queues expected outputs per cycle.
module tb_rr_lease_arbiter;

    localparam int unsigned LEASE = 8;
`ifdef RR_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       exp;
    } obs_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'd0;
    logic       lock  = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       expired;

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t sb_q[$];

    int   m_owner = -1;
    int   m_len   = 0;
    int   m_ptr   = 0;

    rr_lease_arbiter #(.LEASE_CYCLES(LEASE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_len   = 0;
        m_ptr   = 0;
    endfunction

    // Advance the model one clock with the inputs about to be sampled; queue the outputs it predicts.
    function automatic void model_advance(input logic [3:0] r, input logic l);
        obs_t o;
        bit   frozen;
        bit   found;
        int   c;
        frozen = LOCK_ON && l;
        o.exp  = 1'b0;
        if (m_owner >= 0) begin
            if (!r[2'(m_owner)]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else if (LEASE != 0 && m_len == int'(LEASE) && !frozen) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                o.exp   = 1'b1;
            end else if (!frozen) begin
                m_len++;
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && r[2'(c)]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_len   = 1;
                end
            end
        end
        o.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        o.id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        o.valid = (m_owner >= 0);
        sb_q.push_back(o);
    endfunction

    task automatic step(input logic [3:0] r, input logic l);
        obs_t e;
        @(negedge clk);
        req  = r;
        lock = l;
        model_advance(r, l);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("gnt",       32'(gnt),       32'(e.gnt));
            check("gnt_id",    32'(gnt_id),    32'(e.id));
            check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
            check("expired",   32'(expired),   32'(e.exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int   n_exp;
        int   run_len;
        int   first_run;
        bit   prev_v;
        logic [1:0] order_q[$];
        int   exp_order[5];
        logic [3:0] cur_req;
        logic       cur_lock;

        exp_order = '{0, 1, 2, 3, 0};

        // Reset held with all requesters active.
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_gnt",     32'(gnt),       32'd0);
            check("rst_gnt_id",  32'(gnt_id),    32'd0);
            check("rst_valid",   32'(gnt_valid), 32'd0);
            check("rst_expired", 32'(expired),   32'd0);
        end
        #1 rst_n = 1'b1;
        model_reset();

        // Fairness: five tenures of 8 with 1-cycle gaps.
        n_exp  = 0;
        prev_v = 1'b0;
        for (int i = 0; i < 44; i++) begin
            step(4'b1111, 1'b0);
            if (i == 0) check("first_gnt", 32'(gnt), 32'h1);
            if (gnt_valid && !prev_v) order_q.push_back(gnt_id);
            if (expired) n_exp++;
            prev_v = gnt_valid;
        end
        check("fair_exp_pulses", 32'(n_exp), 32'd4);
        check("fair_order_len", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < order_q.size(); i++)
            check("fair_order", 32'(order_q[i]), 32'(exp_order[i]));

        repeat (3) step(4'b0000, 1'b0);

        // Async reset in the middle of requester 2's tenure.
        repeat (3) step(4'b0100, 1'b0);
        check("pre_rst_id", 32'(gnt_id), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        req = 4'b0000;
        #1;
        check("midrst_gnt",     32'(gnt),       32'd0);
        check("midrst_valid",   32'(gnt_valid), 32'd0);
        check("midrst_expired", 32'(expired),   32'd0);
        sb_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Release and rotation; the grant to 0 also shows ptr returned to 0.
        for (int i = 0; i < 3; i++) step(4'b0101, 1'b0);
        check("rot_owner0", 32'(gnt), 32'h1);
        step(4'b0100, 1'b0);
        check("rot_gap", 32'(gnt_valid), 32'd0);
        step(4'b0100, 1'b0);
        check("rot_gnt", 32'(gnt), 32'h4);
        check("rot_id", 32'(gnt_id), 32'd2);
        repeat (3) step(4'b0000, 1'b0);

        // Lease expiry with a lone requester; lock is driven high.
        n_exp     = 0;
        run_len   = 0;
        first_run = -1;
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 1'b1);
            if (expired) n_exp++;
            if (gnt_valid) run_len++;
            else if (first_run < 0 && run_len > 0) first_run = run_len;
        end
`ifndef RR_ARB_LOCK_EN
        check("lease_exp_pulses", 32'(n_exp), 32'd2);
        check("lease_tenure", 32'(first_run), 32'(LEASE));
`endif
        repeat (2) step(4'b0000, 1'b0);

        // Owner drops request exactly when the lease would expire.
        step(4'b0001, 1'b0);
        for (int i = 0; i < 20 && m_len < int'(LEASE); i++) step(4'b0001, 1'b0);
        check("drop_len", 32'(m_len), 32'(LEASE));
        step(4'b0000, 1'b0);
        check("drop_no_exp", 32'(expired), 32'd0);
        check("drop_gnt", 32'(gnt), 32'd0);
        step(4'b0000, 1'b0);
        check("drop_no_exp2", 32'(expired), 32'd0);

        // Random traffic, requests held for a few cycles at a time.
        cur_req  = 4'd0;
        cur_lock = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) cur_lock = ~cur_lock;
            step(cur_req, cur_lock);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_lease_arbiter.md
Name: rr_lease_arbiter

Overview:
- Round-robin arbiter that shares one gate-evaluation lane among four requesters (e.g. ui_in nibbles feeding the AND/OR/XOR lane).
- Issues a registered one-hot grant and bounds each tenure with a lease timer.
- Inserts a fixed one-cycle turnaround between owners.
- Sits between the tt_um top-level input decode and the lane datapath; the datapath output is qualified by gnt_valid.

Parameters:
- LEASE_CYCLES, 8, maximum consecutive grant cycles per tenure; 0 = no timeout; legal range 0..255.
- CW, $clog2(LEASE_CYCLES+1) (min 1), lease counter width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester request level; bit i = requester i.
- lock  input  1  owner lease-extend request; used only with RR_ARB_LOCK_EN, otherwise ignored.
- gnt  output  4  registered one-hot grant, or all zero.
- gnt_id  output  2  index of current owner; 0 when gnt_valid=0.
- gnt_valid  output  1  OR of gnt.
- expired  output  1  one-cycle pulse when a tenure is ended by lease timeout.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, gnt_id=0, gnt_valid=0, expired=0.
  - state=IDLE, ptr=0, cnt=0.
  - Asserting rst_n mid-tenure clears gnt in the same cycle, with no expired pulse.
- States: IDLE, GRANT, GAP.
- Arbitration in IDLE or GAP:
  - Pick the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - If found: next state GRANT, gnt<=onehot(i), gnt_id<=i, cnt<=1.
  - If none: remain or return to IDLE.
- Latency: req rising in cycle N (state IDLE) gives gnt visible in cycle N+1.
- GRANT, release: if req[owner]=0, then next cycle gnt=0, state GAP, ptr<=owner+1 mod 4.
- GRANT, lease expiry: if LEASE_CYCLES!=0, cnt==LEASE_CYCLES and req[owner]=1, then:
  - next cycle gnt=0, expired=1 for exactly one cycle;
  - state GAP, ptr<=owner+1.
- GRANT, otherwise: hold grant, cnt<=cnt+1. The counter saturates and never wraps.
- Owner tenure: exactly LEASE_CYCLES cycles of gnt high under continuous request.
- GAP: always exactly one cycle of gnt=0, then arbitrates as above. Minimum owner-to-owner gap is 1 cycle.
- Non-owner req changes during GRANT are ignored; no preemption.
- Expired owner still requesting becomes lowest priority. It is regranted after GAP only if no other req is set.
- Simultaneous owner drop and lease expiry in the same cycle: treated as a release, expired=0.
- ptr wraps 3->0.
- gnt, gnt_id, gnt_valid and expired are all flop outputs; no combinational path from req to any output.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - While the owner holds lock=1, cnt is frozen and expiry is suppressed.
  - Release on req drop still applies.
  - When lock falls, counting resumes from the frozen value.
  - lock is sampled only in GRANT.
- Undefined: lock port present but unused; the lease always enforced.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles with req=4'b1111 -> all outputs 0. On release, gnt=4'b0001 one cycle after first sampled edge.
- Release and rotation: req=4'b0101 held, then drop req[0] after 3 grant cycles -> gnt=0001 for 3 cycles, one cycle gnt=0, then gnt=0100, gnt_id=2.
- Lease expiry, LEASE_CYCLES=8: req=4'b0001 held -> gnt=0001 for exactly 8 cycles, expired=1 in the single gap cycle, then regrant of 0001.
- Fairness: req=4'b1111 held -> grant order 0,1,2,3,0, each for 8 cycles separated by 1-cycle gaps, with 4 expired pulses.
- Corner cases:
  - owner drops req in the same cycle cnt==8 -> no expired pulse;
  - asynchronous reset mid-grant -> gnt=0 immediately, ptr back to 0.
- RR_ARB_LOCK_EN defined: lock=1 from grant cycle 3 to cycle 20 -> gnt held 20+ cycles with no expiry. After lock falls, expiry occurs 5 cycles later.
